// File: rtl/zbt_client_pkg.sv
// Shared types and constants for the ZBT memory client.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zbt_client_pkg;

    localparam int ZBT_ADDR_W     = 19;
    localparam int ZBT_DATA_W     = 36;
    // rd_req sample cycle to rd_data_valid cycle
    localparam int READ_LATENCY   = 4;
    // valid bits tracked between issue and the cycle read data is on the bus
    localparam int RD_PIPE_STAGES = READ_LATENCY - 1;

    // One buffered camera write
    typedef struct packed {
        logic [ZBT_ADDR_W-1:0] addr;
        logic [ZBT_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/zbt_wr_fifo.sv
// Synchronous write FIFO with first-word-fall-through head (DEPTH power of two, >= 2).
// Latency: a pushed entry is visible on head_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop same cycle allowed.
module zbt_wr_fifo
    import zbt_client_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_vld,
    input  wr_entry_t push_dat,
    input  logic      pop_vld,
    output wr_entry_t head_dat,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    wr_entry_t      mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    // Flags, qualified handshakes and next pointer values
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push  = push_vld & ~full;
        do_pop   = pop_vld & ~empty;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
        head_dat = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Pointer state; reset empties the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/zbt_client.sv
// ZBT client: read-priority arbitration of display reads vs buffered camera writes; ZBT_CLIENT_FRAME_SKIP_EN enables per-frame write skipping.
// Latency: rd_req to rd_data_valid 4 cycles; accepted write to zbt_we at least 2 cycles.
// Backpressure: reads never stall; wr_ready = FIFO not full (drained only in cycles without rd_req).
module zbt_client
    import zbt_client_pkg::*;
#(
    // ADDR_W/DATA_W must match the package widths used by wr_entry_t
    parameter int ADDR_W     = ZBT_ADDR_W,
    parameter int DATA_W     = ZBT_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int SKIP_N     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_start,
    output logic              zbt_cen,
    output logic              zbt_we,
    output logic [ADDR_W-1:0] zbt_addr,
    output logic [DATA_W-1:0] zbt_write_data,
    input  logic [DATA_W-1:0] zbt_read_data
);

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      fifo_push;
    logic                      store_frame;
    wr_entry_t                 fifo_head;
    wr_entry_t                 fifo_in;

    logic                      zbt_cen_q, zbt_cen_d;
    logic                      zbt_we_q, zbt_we_d;
    logic [ADDR_W-1:0]         zbt_addr_q, zbt_addr_d;
    logic [DATA_W-1:0]         zbt_wdata_q, zbt_wdata_d;
    logic [RD_PIPE_STAGES-1:0] rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;
    logic                      rd_data_valid_q, rd_data_valid_d;

`ifdef ZBT_CLIENT_FRAME_SKIP_EN
    localparam int CNT_W = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Frame counter wraps at SKIP_N; pushes in this cycle see the old count
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = (frame_cnt_q == CNT_W'(SKIP_N - 1)) ? '0 : frame_cnt_q + CNT_W'(1);
        end
        store_frame = (frame_cnt_q == '0);
    end

    // Frame counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    // Every frame is stored; frame_start and SKIP_N have no effect
    logic unused_frame_cfg;
    assign unused_frame_cfg = frame_start ^ (SKIP_N == 0);
    assign store_frame      = 1'b1;
`endif

    // Skipped frames still handshake so the camera never stalls; data is dropped
    assign wr_ready  = ~fifo_full;
    assign fifo_push = wr_valid & ~fifo_full & store_frame;
    assign fifo_in   = '{addr: wr_addr, data: wr_data};

    zbt_wr_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (fifo_push),
        .push_dat (fifo_in),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Read-priority arbitration, read valid pipeline and read data capture
    always_comb begin
        zbt_cen_d       = 1'b1;
        zbt_we_d        = 1'b0;
        zbt_addr_d      = zbt_addr_q;
        zbt_wdata_d     = zbt_wdata_q;
        fifo_pop        = 1'b0;
        if (rd_req) begin
            zbt_addr_d = rd_addr;
        end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            zbt_we_d    = 1'b1;
            zbt_addr_d  = fifo_head.addr;
            zbt_wdata_d = fifo_head.data;
        end
        rd_vld_d        = {rd_vld_q[RD_PIPE_STAGES-2:0], rd_req};
        rd_data_valid_d = rd_vld_q[RD_PIPE_STAGES-1];
        rd_data_d       = rd_vld_q[RD_PIPE_STAGES-1] ? zbt_read_data : rd_data_q;
    end

    // Registered driver outputs and read return; reset drops in-flight reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zbt_cen_q       <= 1'b0;
            zbt_we_q        <= 1'b0;
            zbt_addr_q      <= '0;
            zbt_wdata_q     <= '0;
            rd_vld_q        <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            zbt_cen_q       <= zbt_cen_d;
            zbt_we_q        <= zbt_we_d;
            zbt_addr_q      <= zbt_addr_d;
            zbt_wdata_q     <= zbt_wdata_d;
            rd_vld_q        <= rd_vld_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    assign zbt_cen        = zbt_cen_q;
    assign zbt_we         = zbt_we_q;
    assign zbt_addr       = zbt_addr_q;
    assign zbt_write_data = zbt_wdata_q;
    assign rd_data        = rd_data_q;
    assign rd_data_valid  = rd_data_valid_q;

endmodule

// File: tb/tb_zbt_client.sv
// Directed bench for zbt_client with a 2-cycle ZBT driver read model.
// Latency: checks read return in cycle 4 and write issue in cycle 2 after acceptance.
// Backpressure: checks wr_ready drop on a full FIFO under sustained reads.
module tb_zbt_client;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic [35:0] rd_data;
    logic        rd_data_valid;
    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        wr_ready;
    logic        frame_start;
    logic        zbt_cen;
    logic        zbt_we;
    logic [18:0] zbt_addr;
    logic [35:0] zbt_write_data;
    logic [35:0] zbt_read_data;

    int n_cmp = 0;
    int n_err = 0;

    zbt_client u_dut (
        .clk            (clk),
        .reset          (reset),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .frame_start    (frame_start),
        .zbt_cen        (zbt_cen),
        .zbt_we         (zbt_we),
        .zbt_addr       (zbt_addr),
        .zbt_write_data (zbt_write_data),
        .zbt_read_data  (zbt_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen by the driver model: 0x10 -> 0x123456789
    function automatic logic [35:0] mem_word(input logic [18:0] a);
        return 36'h123456799 ^ {17'b0, a};
    endfunction

    // Driver model: address of a read in cycle 1 returns data in cycle 3
    logic        m_v1, m_v2;
    logic [18:0] m_a1, m_a2;
    always @(posedge clk) begin
        if (reset) begin
            m_v1 <= 1'b0;
            m_v2 <= 1'b0;
            m_a1 <= '0;
            m_a2 <= '0;
        end else begin
            m_v1 <= zbt_cen & ~zbt_we;
            m_a1 <= zbt_addr;
            m_v2 <= m_v1;
            m_a2 <= m_a1;
        end
    end
    assign zbt_read_data = m_v2 ? mem_word(m_a2) : 36'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Offer n consecutive writes, then check the issue stream (or its absence)
    task automatic write_burst(input int n, input logic [18:0] base, input bit store);
        logic exp_we;
        for (int k = 0; k <= n + 2; k++) begin
            rd_req   = 1'b0;
            wr_valid = (k < n);
            wr_addr  = 19'(base + 19'(k));
            wr_data  = 36'(36'hB0000 + 36'(base) + 36'(k));
            if (k < n) check_eq($sformatf("burst%0h_wr_ready_k%0d", base, k), wr_ready, 1'b1);
            tick;
            exp_we = store && (k + 1 >= 2) && (k + 1 <= n + 1);
            check_eq($sformatf("burst%0h_we_c%0d", base, k + 1), zbt_we, exp_we);
            if (exp_we) begin
                check_eq($sformatf("burst%0h_addr_c%0d", base, k + 1), zbt_addr, 19'(base + 19'(k - 1)));
                check_eq($sformatf("burst%0h_data_c%0d", base, k + 1), zbt_write_data,
                         36'(36'hB0000 + 36'(base) + 36'(k - 1)));
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic frame_pulse;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    int n_vld;
    int n_we;

    initial begin
        reset       = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        frame_start = 1'b0;

        // Reset state
        repeat (3) tick;
        check_eq("rst_cen", zbt_cen, 1'b0);
        check_eq("rst_we", zbt_we, 1'b0);
        check_eq("rst_addr", zbt_addr, 19'h0);
        check_eq("rst_wdata", zbt_write_data, 36'h0);
        check_eq("rst_rd_data", rd_data, 36'h0);
        check_eq("rst_rd_vld", rd_data_valid, 1'b0);
        reset = 1'b0;
        tick;
        check_eq("rel_cen", zbt_cen, 1'b1);
        check_eq("rel_wr_ready", wr_ready, 1'b1);
        check_eq("rel_we", zbt_we, 1'b0);

        // Single read of 0x10
        rd_req  = 1'b1;
        rd_addr = 19'h10;
        tick;
        rd_req = 1'b0;
        check_eq("rd1_addr_c1", zbt_addr, 19'h10);
        check_eq("rd1_we_c1", zbt_we, 1'b0);
        check_eq("rd1_vld_c1", rd_data_valid, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            tick;
            check_eq($sformatf("rd1_vld_c%0d", c), rd_data_valid, (c == 4));
            if (c == 4) check_eq("rd1_data_c4", rd_data, 36'h123456789);
        end

        // Four back-to-back reads 0x100..0x103
        for (int c = 0; c < 10; c++) begin
            rd_req  = (c < 4);
            rd_addr = 19'(19'h100 + 19'(c));
            tick;
            check_eq($sformatf("rd4_vld_c%0d", c + 1), rd_data_valid, (c + 1 >= 4) && (c + 1 <= 7));
            if ((c + 1 >= 4) && (c + 1 <= 7))
                check_eq($sformatf("rd4_data_c%0d", c + 1), rd_data, mem_word(19'(19'h100 + 19'(c - 3))));
        end
        rd_req = 1'b0;
        tick;

        // Reads held 12 cycles while 9 writes are offered
        for (int c = 0; c < 22; c++) begin
            rd_req   = (c < 12);
            rd_addr  = 19'(19'h180 + 19'(c));
            wr_valid = (c < 9);
            wr_addr  = 19'(19'h200 + 19'(c));
            wr_data  = 36'(36'hA000 + 36'(c));
            if (c < 9) check_eq($sformatf("full_wr_ready_c%0d", c), wr_ready, (c < 8));
            tick;
            check_eq($sformatf("full_we_c%0d", c + 1), zbt_we, (c + 1 >= 13) && (c + 1 <= 20));
            if (c < 12) check_eq($sformatf("full_rdaddr_c%0d", c + 1), zbt_addr, 19'(19'h180 + 19'(c)));
            if ((c + 1 >= 13) && (c + 1 <= 20)) begin
                check_eq($sformatf("full_waddr_c%0d", c + 1), zbt_addr, 19'(19'h200 + 19'(c - 12)));
                check_eq($sformatf("full_wdata_c%0d", c + 1), zbt_write_data, 36'(36'hA000 + 36'(c - 12)));
            end
        end
        wr_valid = 1'b0;
        check_eq("full_wr_ready_after", wr_ready, 1'b1);

        // Frame skipping (SKIP_N = 2 when enabled)
        write_burst(1, 19'h300, 1'b1);
        frame_pulse;
`ifdef ZBT_CLIENT_FRAME_SKIP_EN
        write_burst(5, 19'h310, 1'b0);
`else
        write_burst(5, 19'h310, 1'b1);
`endif
        frame_pulse;
        write_burst(2, 19'h320, 1'b1);

        // Reset during an outstanding read, with a write parked in the FIFO
        rd_req   = 1'b1;
        rd_addr  = 19'h40;
        wr_valid = 1'b1;
        wr_addr  = 19'h500;
        wr_data  = 36'h5A5;
        tick;
        rd_addr  = 19'h41;
        wr_valid = 1'b0;
        tick;
        reset  = 1'b1;
        rd_req = 1'b0;
        #1;
        check_eq("mid_rst_cen", zbt_cen, 1'b0);
        check_eq("mid_rst_vld", rd_data_valid, 1'b0);
        tick;
        tick;
        reset = 1'b0;
        n_vld = 0;
        n_we  = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (rd_data_valid) n_vld++;
            if (zbt_we) n_we++;
        end
        check_eq("mid_rst_strobes", 64'(n_vld), 64'd0);
        check_eq("mid_rst_writes", 64'(n_we), 64'd0);
        check_eq("mid_rst_cen_after", zbt_cen, 1'b1);
        check_eq("mid_rst_wr_ready", wr_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
